// File: rtl/button_event_decoder.sv
// Button event decoder: turns a clean, debounced button level into one-cycle
// events (press, release, short, long, auto-repeat) plus the held level.
// Define DOUBLE_CLICK_EN to add double-click detection: o_short is deferred
// until the release-to-press gap expires, and a second press within p_gap
// cycles pulses o_double together with o_press.
// All outputs are registered; events appear one cycle after the i_level
// sample that caused them.
module button_event_decoder #(
  parameter int unsigned p_long   = 50,
  parameter int unsigned p_repeat = 20,
  parameter int unsigned p_gap    = 30
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_held,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_double
);

  localparam int unsigned MaxLr  = (p_long > p_repeat) ? p_long : p_repeat;
  localparam int unsigned CntMax = (MaxLr > p_gap) ? MaxLr : p_gap;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] LongLast = CntW'(p_long - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(p_repeat - 1);
`ifdef DOUBLE_CLICK_EN
  localparam logic [CntW-1:0] GapLast  = CntW'(p_gap - 1);
`endif

  typedef enum logic [2:0] {
    StStart,
    StLocked,
    StIdle,
    StPressed,
    StLong,
    StGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

`ifdef DOUBLE_CLICK_EN
  // Set by the second press of a double-click; hides o_short on its release.
  logic dbl_q;
`else
  assign o_double = 1'b0;
`endif

  // Decoder FSM with registered event outputs; counter clears on every state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StStart;
      cnt_q     <= '0;
      o_held    <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      o_double  <= 1'b0;
      dbl_q     <= 1'b0;
`endif
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      o_double  <= 1'b0;
`endif
      case (state_q)
        // A button already down at reset must be released before it counts.
        StStart: begin
          cnt_q   <= '0;
          state_q <= i_level ? StLocked : StIdle;
        end

        StLocked: begin
          if (!i_level) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end

        StIdle: begin
          if (i_level) begin
            state_q <= StPressed;
            cnt_q   <= '0;
            o_press <= 1'b1;
            o_held  <= 1'b1;
          end
        end

        // Release is checked first so it beats the long threshold.
        StPressed: begin
          if (!i_level) begin
            cnt_q     <= '0;
            o_held    <= 1'b0;
            o_release <= 1'b1;
`ifdef DOUBLE_CLICK_EN
            if (dbl_q) begin
              state_q <= StIdle;
              dbl_q   <= 1'b0;
            end else begin
              state_q <= StGap;
            end
`else
            o_short <= 1'b1;
            state_q <= StIdle;
`endif
          end else if (cnt_q == LongLast) begin
            state_q <= StLong;
            cnt_q   <= '0;
            o_long  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Release beats repeat; repeat period restarts from zero each pulse.
        StLong: begin
          if (!i_level) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            o_held    <= 1'b0;
            o_release <= 1'b1;
`ifdef DOUBLE_CLICK_EN
            dbl_q     <= 1'b0;
`endif
          end else if (cnt_q == RepLast) begin
            cnt_q    <= '0;
            o_repeat <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef DOUBLE_CLICK_EN
        // Waiting for a second press; a press on the timeout cycle still wins.
        StGap: begin
          if (i_level) begin
            state_q  <= StPressed;
            cnt_q    <= '0;
            o_press  <= 1'b1;
            o_double <= 1'b1;
            o_held   <= 1'b1;
            dbl_q    <= 1'b1;
          end else if (cnt_q == GapLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            o_short <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        default: begin
          state_q <= StStart;
          cnt_q   <= '0;
          o_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with p_long=8, p_repeat=4, p_gap=5.
// Table of per-cycle {reset, level, expected outputs} vectors plus a
// hand-written long-hold sequence. Builds with or without DOUBLE_CLICK_EN.
module tb_button_event_decoder;

  localparam int unsigned PLong   = 8;
  localparam int unsigned PRepeat = 4;
  localparam int unsigned PGap    = 5;

  // Output bundle bits: {held, press, release, short, long, repeat, double}
  localparam logic [6:0] H  = 7'b1000000;
  localparam logic [6:0] P  = 7'b0100000;
  localparam logic [6:0] R  = 7'b0010000;
  localparam logic [6:0] S  = 7'b0001000;
  localparam logic [6:0] L  = 7'b0000100;
  localparam logic [6:0] RP = 7'b0000010;
  localparam logic [6:0] D  = 7'b0000001;
  localparam logic [6:0] Z  = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  logic level;
  logic o_held, o_press, o_release, o_short, o_long, o_repeat, o_double;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       lvl;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  button_event_decoder #(
    .p_long  (PLong),
    .p_repeat(PRepeat),
    .p_gap   (PGap)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_level  (level),
    .o_held   (o_held),
    .o_press  (o_press),
    .o_release(o_release),
    .o_short  (o_short),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .o_double (o_double)
  );

  assign outs = {o_held, o_press, o_release, o_short, o_long, o_repeat, o_double};

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic l, input logic [6:0] e, input string t);
    vec_t v;
    v.rst = r;
    v.lvl = l;
    v.exp = e;
    v.tag = t;
    vecs.push_back(v);
  endtask

  // Release of a plain short press, followed by five idle cycles.
  task automatic add_short_release(input string t);
`ifdef DOUBLE_CLICK_EN
    add(1'b0, 1'b0, R, {t, "_rel"});
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, Z, {t, "_gap"});
    add(1'b0, 1'b0, S, {t, "_deferred_short"});
`else
    add(1'b0, 1'b0, R | S, {t, "_rel"});
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, Z, {t, "_idle"});
`endif
  endtask

  task automatic check_bits(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (held,press,rel,short,long,rep,dbl)",
               name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int press_at;
    int long_at;
    int n_long;
    int n_held;
    int reps[$];

    rst   = 1'b1;
    level = 1'b0;

    // Reset and startup into IDLE
    add(1'b1, 1'b0, Z, "reset");
    add(1'b1, 1'b0, Z, "reset_hold");
    add(1'b0, 1'b0, Z, "start_idle");
    add(1'b0, 1'b0, Z, "idle");

    // Three-cycle press
    add(1'b0, 1'b1, H | P, "short_press");
    add(1'b0, 1'b1, H, "short_hold1");
    add(1'b0, 1'b1, H, "short_hold2");
    add_short_release("short");

    // One-cycle glitch
    add(1'b0, 1'b1, H | P, "glitch_press");
    add_short_release("glitch");

    // Release on the cycle the counter reaches p_long-1
    add(1'b0, 1'b1, H | P, "thr_press");
    for (int i = 0; i < 7; i++) add(1'b0, 1'b1, H, "thr_hold");
    add_short_release("thr");

    // Held through reset release -> locked until let go
    add(1'b1, 1'b1, Z, "lock_rst");
    add(1'b0, 1'b1, Z, "lock_start");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, Z, "locked");
    add(1'b0, 1'b0, Z, "lock_free");
    add(1'b0, 1'b0, Z, "lock_idle");
    add(1'b0, 1'b1, H | P, "post_lock_press");
    add_short_release("post_lock");

    // Reset mid-PRESSED at count 5
    add(1'b0, 1'b1, H | P, "mid_press");
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, H, "mid_hold");
    add(1'b1, 1'b1, Z, "mid_rst");
    add(1'b0, 1'b1, Z, "mid_rst_after");
    add(1'b0, 1'b1, Z, "mid_locked");
    add(1'b0, 1'b0, Z, "mid_free");
    add(1'b0, 1'b0, Z, "mid_idle");

`ifdef DOUBLE_CLICK_EN
    // Re-press 3 cycles after release -> double click, no shorts
    add(1'b0, 1'b1, H | P, "dc_first");
    add(1'b0, 1'b1, H, "dc_first_hold");
    add(1'b0, 1'b0, R, "dc_first_rel");
    add(1'b0, 1'b0, Z, "dc_gap1");
    add(1'b0, 1'b0, Z, "dc_gap2");
    add(1'b0, 1'b1, H | P | D, "dc_second");
    add(1'b0, 1'b1, H, "dc_second_hold");
    add(1'b0, 1'b0, R, "dc_second_rel");
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, Z, "dc_no_short");

    // Re-press 6 cycles after release -> deferred short, then plain press
    add(1'b0, 1'b1, H | P, "late_first");
    add(1'b0, 1'b0, R, "late_rel");
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, Z, "late_gap");
    add(1'b0, 1'b0, S, "late_short");
    add(1'b0, 1'b1, H | P, "late_press");
    add_short_release("late");

    // Press on the timeout cycle wins
    add(1'b0, 1'b1, H | P, "edge_first");
    add(1'b0, 1'b0, R, "edge_rel");
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, Z, "edge_gap");
    add(1'b0, 1'b1, H | P | D, "edge_press");
    add(1'b0, 1'b0, R, "edge_second_rel");
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, Z, "edge_no_short");

    // Reset while in GAP drops the pending short
    add(1'b0, 1'b1, H | P, "gaprst_press");
    add(1'b0, 1'b0, R, "gaprst_rel");
    add(1'b0, 1'b0, Z, "gaprst_gap");
    add(1'b1, 1'b0, Z, "gaprst_rst");
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, Z, "gaprst_no_short");
`endif

    // Drive before each rising edge, check on the following falling edge
    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      level = vecs[i].lvl;
      @(negedge clk);
      check_bits($sformatf("%s[%0d]", vecs[i].tag, i), outs, vecs[i].exp);
    end

    // Long hold: 22 high samples, then release
    press_at = -1;
    long_at  = -1;
    n_long   = 0;
    n_held   = 0;
    rst      = 1'b0;
    level    = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (o_press) press_at = c;
      if (o_long) begin
        long_at = c;
        n_long++;
      end
      if (o_repeat) reps.push_back(c);
      if (o_held) n_held++;
      if (o_short || o_release) check_int("long_unexpected_release", c, -1);
    end
    check_int("long_press_cycle", press_at, 0);
    check_int("long_after_press", long_at - press_at, int'(PLong));
    check_int("long_count", n_long, 1);
    check_int("long_held_cycles", n_held, 22);
    check_int("repeat_count", reps.size(), 3);
    for (int k = 0; k < reps.size() && k < 3; k++)
      check_int($sformatf("repeat%0d_after_long", k), reps[k] - long_at, int'(PRepeat) * (k + 1));
    level = 1'b0;
    @(negedge clk);
    check_bits("long_release", outs, R);
    @(negedge clk);
    check_bits("long_after_release", outs, Z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
